// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot loader for a CPU instruction memory. On a start request
//               it accepts len 32-bit words over a valid/ready stream. Each
//               word is written to consecutive instruction-memory addresses
//               starting at 0. The loader then holds the CPU in reset for
//               FLUSH_CYC more cycles and releases it (RUN).
//               A start with an out-of-range length is rejected with an err
//               pulse. A valid start in RUN reloads the memory.
// Optional    : define LOADER_CHECKSUM_EN to add the checksum output, the
//               mod-2^32 sum of all words accepted since the last start.
// Ports       : clk          - clock, rising edge
//               rst          - asynchronous active-high reset
//               start, len   - load request and word count (1..2^ADDR_W)
//               s_valid, s_data, s_ready - source word stream
//               imem_wr_en, imem_wr_addr, imem_wr_data - registered write port
//               cpu_rst_n    - active-low CPU reset (released only in RUN)
//               busy         - loading or flushing
//               done         - one-cycle pulse on the first RUN cycle
//               err          - one-cycle pulse after a rejected start
//               checksum     - running word sum (LOADER_CHECKSUM_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int FLUSH_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_wr_addr,
    output logic [31:0]       imem_wr_data,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
`ifdef LOADER_CHECKSUM_EN
    output logic [31:0]       checksum,
`endif
    output logic              err
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;
    localparam logic [1:0] c_RUN   = 2'd3;

    // The word counter and length are ADDR_W+1 bits wide so that a full-depth
    // load (len == 2^ADDR_W) is representable and the counter cannot wrap.
    localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    localparam int               c_FC_W       = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [c_FC_W-1:0] c_FC_ONE     = c_FC_W'(1);
    localparam logic [c_FC_W-1:0] c_FLUSH_LAST = (FLUSH_CYC > 0) ? c_FC_W'(FLUSH_CYC - 1) : '0;

    logic [1:0]        r_state;
    logic [ADDR_W:0]   r_cnt;
    logic [ADDR_W:0]   r_len;
    logic [c_FC_W-1:0] r_flush_cnt;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_wr_data;
    logic              r_done;
    logic              r_err;

    logic w_idle_or_run;
    logic w_len_ok;
    logic w_start_ok;
    logic w_start_bad;
    logic w_accept;
    logic w_last_word;

    assign w_idle_or_run = (r_state == c_IDLE) || (r_state == c_RUN);
    assign w_len_ok      = (len != '0) && (len <= c_DEPTH);
    assign w_start_ok    = start && w_len_ok && w_idle_or_run;
    assign w_start_bad   = start && !w_len_ok && w_idle_or_run;
    assign w_accept      = s_valid && (r_state == c_LOAD);
    assign w_last_word   = w_accept && (r_cnt == (r_len - c_ONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_len       <= '0;
            r_flush_cnt <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Strobes default low; they are raised only for one cycle below.
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= w_start_bad;

            case (r_state)
                c_IDLE, c_RUN: begin
                    if (w_start_ok) begin
                        r_state <= c_LOAD;
                        r_cnt   <= '0;
                        r_len   <= len;
                    end
                end
                c_LOAD: begin
                    if (w_accept) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_cnt[ADDR_W-1:0];
                        r_wr_data <= s_data;
                        r_cnt     <= r_cnt + c_ONE;
                        if (w_last_word) begin
                            if (FLUSH_CYC == 0) begin
                                r_state <= c_RUN;
                                r_done  <= 1'b1;
                            end else begin
                                r_state     <= c_FLUSH;
                                r_flush_cnt <= '0;
                            end
                        end
                    end
                end
                c_FLUSH: begin
                    if (r_flush_cnt == c_FLUSH_LAST) begin
                        r_state <= c_RUN;
                        r_done  <= 1'b1;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + c_FC_ONE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + s_data;
        end
    end

    assign checksum = r_checksum;
`endif

    // Handshake and CPU reset depend on state only, so s_ready has no
    // combinational path from s_valid.
    assign s_ready      = (r_state == c_LOAD);
    assign busy         = (r_state == c_LOAD) || (r_state == c_FLUSH);
    assign cpu_rst_n    = (r_state == c_RUN);
    assign imem_wr_en   = r_wr_en;
    assign imem_wr_addr = r_wr_addr;
    assign imem_wr_data = r_wr_data;
    assign done         = r_done;
    assign err          = r_err;

endmodule
`default_nettype wire
